// File: rtl/signal_level_meter.sv
// Multi-channel audio level meter: per-frame peak to a log-scaled
// thermometer bar with one-step decay, plus a held clip flag.
module signal_level_meter #(
  parameter int WIDTH       = 24,
  parameter int CHANNELS    = 2,
  parameter int LEVELS      = 10,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*WIDTH-1:0]    sample_data,
  input  logic                         sample_valid,
  input  logic                         frame_tick,
  output logic [CHANNELS*LEVELS-1:0]   level_bar,
  output logic [CHANNELS-1:0]          clip,
  output logic                         frame_done
);

  localparam int MW  = WIDTH - 1;
  localparam int LW  = $clog2(LEVELS + 1);
  localparam int OFS = WIDTH - 1 - LEVELS;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {MW{1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {MW{1'b0}}};
  localparam logic [7:0]       HOLD    = 8'(HOLD_FRAMES);

  // Each 6 dB step is one bit of magnitude; the top LEVELS bits drive the bar.
  function automatic logic [LW-1:0] lvl_of(input logic [MW-1:0] p);
    int bl;
    int v;
    bl = 0;
    for (int i = 0; i < MW; i++)
      if (p[i]) bl = i + 1;
    v = bl - OFS;
    if (v < 0) v = 0;
    if (v > LEVELS) v = LEVELS;
    return LW'(v);
  endfunction

  function automatic logic [LEVELS-1:0] therm(input logic [LW-1:0] d);
    logic [LEVELS-1:0] t;
    for (int i = 0; i < LEVELS; i++)
      t[i] = (i < int'(d));
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= frame_tick;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  neg;
    logic [MW-1:0]     mag;
    logic              clip_ev;
    logic [MW-1:0]     acc_q;
    logic              seen_q;
    logic [MW-1:0]     peak;
    logic              fclip;
    logic [LW-1:0]     new_lvl;
    logic [LW-1:0]     disp_q;
    logic [LW-1:0]     disp_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic [LEVELS-1:0] bar_q;
    logic              clip_q;

    assign s   = sample_data[c*WIDTH +: WIDTH];
    assign neg = -s;

    always_comb begin
      mag = s[MW-1:0];
      if (s == MIN_NEG)      mag = {MW{1'b1}};
      else if (s[WIDTH-1])   mag = neg[MW-1:0];
    end

    assign clip_ev = (s == MAX_POS) || (s == MIN_NEG);

    // A sample landing on the tick still belongs to the closing frame.
    assign peak  = (sample_valid && mag > acc_q) ? mag : acc_q;
    assign fclip = seen_q | (sample_valid & clip_ev);

    assign new_lvl = lvl_of(peak);

    always_comb begin
      disp_d = disp_q;
      if (new_lvl >= disp_q) disp_d = new_lvl;
      else if (disp_q != '0) disp_d = disp_q - 1'b1;
      cnt_d = cnt_q;
      if (fclip)             cnt_d = HOLD;
      else if (cnt_q != '0)  cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q  <= '0;
        seen_q <= 1'b0;
        disp_q <= '0;
        cnt_q  <= '0;
        bar_q  <= '0;
        clip_q <= 1'b0;
      end else if (frame_tick) begin
        acc_q  <= '0;
        seen_q <= 1'b0;
        disp_q <= disp_d;
        cnt_q  <= cnt_d;
        bar_q  <= therm(disp_d);
        clip_q <= (cnt_d != '0);
      end else if (sample_valid) begin
        acc_q  <= peak;
        seen_q <= fclip;
      end
    end

    assign level_bar[c*LEVELS +: LEVELS] = bar_q;
    assign clip[c]                       = clip_q;
  end

endmodule

// File: doc/signal_level_meter.md
Name: signal_level_meter

Overview:
Parametrised multi-channel audio level meter. It sits between the audio_codec read path and the board LEDs, and replaces the fixed two-LED, left-only analyser. Per channel, it tracks the peak magnitude over each frame, where a frame is delimited by an external tick (e.g. 60 Hz). At each tick it converts that peak to a log-scaled (6 dB/step) thermometer bar with one-step-per-frame decay, plus a sticky clip indicator.

Parameters:
WIDTH, 24, sample width in bits, two's complement
CHANNELS, 2, number of audio channels metered
LEVELS, 10, LEDs per channel bar (1..WIDTH-1)
HOLD_FRAMES, 30, frames the clip flag stays asserted after the last clipping frame (1..255)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset  input  1  synchronous, active-high reset
sample_data  input  CHANNELS*WIDTH  packed samples; channel c at bits [c*WIDTH +: WIDTH]
sample_valid  input  1  one-cycle strobe; all channels valid (codec read_ready & read)
frame_tick  input  1  one-cycle pulse ending the current frame
level_bar  output  CHANNELS*LEVELS  thermometer bar per channel; channel c at [c*LEVELS +: LEVELS], bit 0 = lowest LED
clip  output  CHANNELS  per-channel sticky clip flag
frame_done  output  1  one-cycle pulse marking that level_bar/clip have just updated

Behaviour:
- Reset (sync, clk edge with reset=1): peak accumulators, displayed levels, hold counters = 0; level_bar = 0, clip = 0, frame_done = 0. Reset overrides tick/valid in the same cycle.
- Magnitude: mag = |sample|, WIDTH-1 bits unsigned. The most negative code (0x800000 at W=24) saturates to 2^(WIDTH-1)-1.
- Clip event: sample equals the maximum positive code or the most negative code.
- Accumulate: on sample_valid, acc[c] <= max(acc[c], mag[c]); clip_seen[c] |= clip event.
- Frame close (frame_tick=1):
  - frame_peak = max(acc, mag if sample_valid this cycle).
  - frame_clip = clip_seen | (clip event if valid).
  - A sample arriving in the tick cycle belongs to the closing frame.
  - acc and clip_seen clear to 0 in the same edge; the new frame starts empty.
- Level mapping:
  - bitlen = index of MSB of frame_peak + 1 (0 if frame_peak = 0).
  - new_lvl = clamp(bitlen - (WIDTH-1-LEVELS), 0, LEVELS).
  - W=24, L=10: new_lvl = max(0, bitlen-13).
- Decay, per channel at tick:
  - if new_lvl >= disp: disp <= new_lvl;
  - else if disp > 0: disp <= disp-1.
  - Bar falls at most one LED per frame and rises instantly.
- Clip hold, per channel at tick:
  - if frame_clip: cnt <= HOLD_FRAMES;
  - else if cnt > 0: cnt <= cnt-1.
  - clip = (cnt != 0).
- Output timing:
  - level_bar[c] = thermometer(disp[c]), i.e. the low disp bits set. It is registered and changes only in the cycle after frame_tick.
  - frame_done is high exactly that cycle.
  - Latency from tick to outputs: 1 clk.
- Between ticks the outputs are stable regardless of sample traffic.
- Back-to-back ticks (consecutive cycles): each is a full frame close. An empty frame gives new_lvl = 0, so the bar decays by 1.
- frame_tick with no samples in the frame: treated as silence.
- Channels are fully independent; no cross-channel arithmetic.
- Registered datapath only; no combinational path from inputs to outputs.

Test Plan:
- Reset then 5 ticks with no samples -> level_bar=0, clip=0, frame_done pulses 1 cycle after each tick.
- W=24/L=10: ch0 samples 0x004000 then 0xFFC000 (-16384), tick -> ch0 bar=10'b0000000011; ch1 with 0x000800 only -> bar=0.
- ch0 sample 0x800000, tick -> ch0 bar=10'h3FF, clip[0]=1. Then 12 silent ticks -> bar steps 9,8,...,0 (0 after the 10th), clip still 1.
- Clip hold: after the clip frame, clip[0] remains 1 through 29 silent ticks and drops after the 30th. A new 0x7FFFFF sample at the 20th frame reloads the count to 30.
- sample_valid with 0x7FFFFF in the same cycle as frame_tick -> counted in the closing frame (bar=0x3FF next cycle). The following frame with 0x000001 only -> bar=0x1FF (decay), not 0x3FF.
- reset asserted mid-frame, with acc holding 0x400000 and clip count=15 -> next tick gives bar=0, clip=0. The same cycle's tick is ignored, and frame_done stays 0 that cycle.
